id_stage: RTL and testbench
===========================

// Module: id_stage
// PURPOSE
//  Decode stage of the pipelined RV32I subset: owns the 32x32 register file, decodes the instruction
//  presented by fetch and drives every *_in port of id_ex. Tracks the last two issued instructions
//  to set rs*_take_prev1 (EX-to-EX forward). Inserts bubbles for hazards forwarding cannot cover.
//  Pipeline order: fetch -> id_stage -> id_ex -> EX -> MEM -> WB (WB writes back through wb_* ports).
// PARAMETERS
//  NOP_RD   5'd0   rd of bubble (bubble = ADDI x0,x0,0; matches id_ex reset contents)
// PORTS
//  clk                   in   1   clock, all state on posedge
//  rst                   in   1   asynchronous, active-low reset
//  instr_in              in   32  instruction word from fetch
//  instr_valid           in   1   instr_in is real; 0 -> issue bubble
//  wb_en                 in   1   WB stage register write enable
//  wb_addr               in   5   WB destination register
//  wb_data               in   32  WB write data
//  stall_out             out  1   1 -> fetch must hold instr_in next cycle
//  rd_addr_out           out  5   to id_ex rd_addr_in
//  rs1_out, rs2_out      out  32  register operands (after WB bypass)
//  writeback_en_out      out  1   instruction writes rd
//  writeback_from_mem_out out 1   result comes from memory (LW)
//  alu_rs2_reg_out       out  1   1 -> ALU B = rs2, 0 -> imm
//  imm_out               out  32  sign-extended I-immediate, 0 for R-type
//  add/sub/xor/or/and_en_out out 1 each  one-hot ALU op
//  rs1/rs2_take_prev1_out out 1 each     forward EX result of previous issued instruction
// BEHAVIOUR
//  Decoding (combinational from instr_in, regfile and tracking state):
//  - 0110011 R: funct3/funct7 000/00 ADD, 000/20 SUB, 100 XOR, 110 OR, 111 AND; alu_rs2_reg=1.
//  - 0010011 I: 000 ADDI, 100 XORI, 110 ORI, 111 ANDI; alu_rs2_reg=0; imm=sext(instr[31:20]).
//  - 0000011 funct3 010 LW: add_en=1, writeback_from_mem=1, alu_rs2_reg=0, imm as I.
//  - Any other encoding, instr_valid=0, stall, or reset asserted: bubble (rd=0, wb_en=1,
//    add_en=1, all other flags/data 0). Unsupported opcodes do not raise stall_out.
//  - rs2 is used only by R-type; I-type/LW ignore instr[24:20] for hazard/forward purposes.
//  Register file: 32x32, x0 reads 0 and ignores writes. Write on posedge when wb_en && wb_addr!=0.
//  - Same-cycle bypass: read of wb_addr (!=0) while wb_en returns wb_data, not stored value.
//  Issue tracking: prev1 = last issued (incl. bubbles), prev2 = one before; each holds rd, wb_en,
//    is_load. On every posedge: prev2<=prev1, prev1<=issued (bubble when stalled). Reset: both = bubble.
//  Hazard (src = used source reg, src!=0; "match p" = p.wb_en && p.rd==src):
//  - match prev1 && prev1.is_load -> stall.          match prev2 -> stall (no MEM forward path).
//  - match prev1 && !prev1.is_load && no stall -> that source's take_prev1=1.
//  - stall_out = hazard && instr_valid; while stalled the bubble shifts in, so load-use costs
//    2 cycles and prev2-only hazard costs 1; re-evaluated each cycle, no separate counter.
//  - rs1 and rs2 independent; either source stalling stalls the instruction (both flags 0).
//  Reset (rst=0, any time): prev1/prev2 cleared to bubble immediately, stall_out=0, outputs = bubble;
//    regfile contents NOT cleared (undefined until written, x0 always 0). Mid-stall reset drops stall.
//  Latency: decode 0 cycles (registered by id_ex); regfile write visible next cycle or via bypass.
// TESTING
//  1 Reset: rst=0 -> stall_out=0, rd_addr_out=0, writeback_en_out=1, add_en_out=1, rest 0.
//  2 WB x5=32'h1234 then ADD x6,x5,x5 -> rs1_out=rs2_out=32'h1234; same-cycle write also bypasses.
//  3 ADDI x1,x0,7 ; ADD x2,x1,x1 -> 2nd issues no stall, rs1/rs2_take_prev1_out=1.
//  4 LW x3,0(x0) ; ADD x4,x3,x0 -> stall_out=1 for 2 cycles, 2 bubbles, ADD issues with take_prev1=0,
//    rs1_out=load data via WB bypass on the 3rd cycle.
//  5 ADDI x1 ; ADDI x9 ; XOR x2,x1,x0 -> 1 stall cycle, then issue with rs1_out from WB bypass.
//  6 Writes to x0, ADD x0 as producer, opcode 1100011 -> x0 reads 0, no forward/stall, bubble emitted.

Source files
------------

// File: rtl/id_stage_if.sv
// Decode-to-id_ex bundle: every field id_stage drives into the id_ex pipeline register.
interface id_stage_if;
    logic [4:0]  rd_addr_out;
    logic [31:0] rs1_out;
    logic [31:0] rs2_out;
    logic        writeback_en_out;
    logic        writeback_from_mem_out;
    logic        alu_rs2_reg_out;
    logic [31:0] imm_out;
    logic        add_en_out;
    logic        sub_en_out;
    logic        xor_en_out;
    logic        or_en_out;
    logic        and_en_out;
    logic        rs1_take_prev1_out;
    logic        rs2_take_prev1_out;

    // Decode stage drives the bundle.
    modport master (
        output rd_addr_out, rs1_out, rs2_out, writeback_en_out, writeback_from_mem_out,
               alu_rs2_reg_out, imm_out, add_en_out, sub_en_out, xor_en_out, or_en_out,
               and_en_out, rs1_take_prev1_out, rs2_take_prev1_out
    );

    // id_ex register (or a bench) consumes it.
    modport slave (
        input rd_addr_out, rs1_out, rs2_out, writeback_en_out, writeback_from_mem_out,
              alu_rs2_reg_out, imm_out, add_en_out, sub_en_out, xor_en_out, or_en_out,
              and_en_out, rs1_take_prev1_out, rs2_take_prev1_out
    );
endinterface

// File: rtl/id_stage.sv
// RV32I-subset decode stage: register file, instruction decode, EX-to-EX forward
// selection and bubble insertion for hazards the single forward path cannot cover.
module id_stage #(
    parameter logic [4:0] NOP_RD = 5'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr_in,
    input  logic        instr_valid,
    input  logic        wb_en,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    output logic        stall_out,
    id_stage_if.master  id_ex
);

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LOAD = 7'b0000011;

    // What the hazard logic needs to remember about an issued instruction.
    typedef struct packed {
        logic [4:0] rd;
        logic       wb_en;
        logic       is_load;
    } issue_t;

    localparam issue_t BUBBLE = '{rd: NOP_RD, wb_en: 1'b1, is_load: 1'b0};

    // Instruction fields
    logic [6:0] opcode;
    logic [4:0] rd;
    logic [2:0] funct3;
    logic [4:0] rs1_addr;
    logic [4:0] rs2_addr;
    logic [6:0] funct7;

    assign opcode   = instr_in[6:0];
    assign rd       = instr_in[11:7];
    assign funct3   = instr_in[14:12];
    assign rs1_addr = instr_in[19:15];
    assign rs2_addr = instr_in[24:20];
    assign funct7   = instr_in[31:25];

    logic [31:0] regs [32];
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;

    logic [4:0] alu_op;     // {add, sub, xor, or, and}
    logic       is_r;
    logic       is_i;
    logic       is_lw;
    logic       legal;

    issue_t prev1;
    issue_t prev2;
    issue_t issued;

    logic uses_rs1;
    logic uses_rs2;
    logic p1_rs1;
    logic p1_rs2;
    logic stall_rs1;
    logic stall_rs2;
    logic hazard;
    logic issue;

    // Register file write port; x0 is never written.
    // NOTE: the register array has no reset -- its contents are architecturally undefined
    // until written, and leaving it out of the reset tree lets it map onto plain storage.
    always_ff @(posedge clk) begin
        if (wb_en && wb_addr != 5'd0) begin
            regs[wb_addr] <= wb_data;
        end
    end

    // Read ports with x0 hardwired to zero and same-cycle bypass of the WB write.
    always_comb begin
        if (rs1_addr == 5'd0)                   rs1_val = '0;
        else if (wb_en && wb_addr == rs1_addr)  rs1_val = wb_data;
        else                                    rs1_val = regs[rs1_addr];

        if (rs2_addr == 5'd0)                   rs2_val = '0;
        else if (wb_en && wb_addr == rs2_addr)  rs2_val = wb_data;
        else                                    rs2_val = regs[rs2_addr];
    end

    // Classify the instruction word and pick the one-hot ALU operation.
    // NOTE: every signal gets a default before the case so no path leaves it unassigned,
    // which is what keeps this block from inferring latches.
    always_comb begin
        alu_op = 5'b00000;
        is_r   = 1'b0;
        is_i   = 1'b0;
        is_lw  = 1'b0;
        unique case (opcode)
            OP_R: begin
                if (funct3 == 3'b000 && funct7 == 7'h00) begin
                    alu_op = 5'b10000; is_r = 1'b1;
                end else if (funct3 == 3'b000 && funct7 == 7'h20) begin
                    alu_op = 5'b01000; is_r = 1'b1;
                end else if (funct3 == 3'b100 && funct7 == 7'h00) begin
                    alu_op = 5'b00100; is_r = 1'b1;
                end else if (funct3 == 3'b110 && funct7 == 7'h00) begin
                    alu_op = 5'b00010; is_r = 1'b1;
                end else if (funct3 == 3'b111 && funct7 == 7'h00) begin
                    alu_op = 5'b00001; is_r = 1'b1;
                end
            end
            OP_I: begin
                case (funct3)
                    3'b000:  begin alu_op = 5'b10000; is_i = 1'b1; end
                    3'b100:  begin alu_op = 5'b00100; is_i = 1'b1; end
                    3'b110:  begin alu_op = 5'b00010; is_i = 1'b1; end
                    3'b111:  begin alu_op = 5'b00001; is_i = 1'b1; end
                    default: ;
                endcase
            end
            OP_LOAD: begin
                if (funct3 == 3'b010) begin
                    alu_op = 5'b10000; is_lw = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign legal = is_r | is_i | is_lw;

    // Hazard detection: prev1 sits in EX, prev2 in MEM. Only EX results can be forwarded,
    // so a load in EX or any producer in MEM forces a bubble.
    always_comb begin
        uses_rs1  = legal && (rs1_addr != 5'd0);
        uses_rs2  = is_r  && (rs2_addr != 5'd0);
        p1_rs1    = uses_rs1 && prev1.wb_en && (prev1.rd == rs1_addr);
        p1_rs2    = uses_rs2 && prev1.wb_en && (prev1.rd == rs2_addr);
        stall_rs1 = (p1_rs1 && prev1.is_load) ||
                    (uses_rs1 && prev2.wb_en && (prev2.rd == rs1_addr));
        stall_rs2 = (p1_rs2 && prev1.is_load) ||
                    (uses_rs2 && prev2.wb_en && (prev2.rd == rs2_addr));
        hazard    = stall_rs1 | stall_rs2;
        stall_out = rst && instr_valid && hazard;
        issue     = rst && instr_valid && legal && !hazard;
    end

    // Drive id_ex: the decoded instruction when it issues, otherwise a bubble.
    always_comb begin
        id_ex.rd_addr_out            = NOP_RD;
        id_ex.rs1_out                = '0;
        id_ex.rs2_out                = '0;
        id_ex.writeback_en_out       = 1'b1;
        id_ex.writeback_from_mem_out = 1'b0;
        id_ex.alu_rs2_reg_out        = 1'b0;
        id_ex.imm_out                = '0;
        id_ex.add_en_out             = 1'b1;
        id_ex.sub_en_out             = 1'b0;
        id_ex.xor_en_out             = 1'b0;
        id_ex.or_en_out              = 1'b0;
        id_ex.and_en_out             = 1'b0;
        id_ex.rs1_take_prev1_out     = 1'b0;
        id_ex.rs2_take_prev1_out     = 1'b0;
        issued                       = BUBBLE;
        if (issue) begin
            id_ex.rd_addr_out            = rd;
            id_ex.rs1_out                = rs1_val;
            id_ex.rs2_out                = is_r ? rs2_val : 32'd0;
            id_ex.writeback_from_mem_out = is_lw;
            id_ex.alu_rs2_reg_out        = is_r;
            id_ex.imm_out                = is_r ? 32'd0 : {{20{instr_in[31]}}, instr_in[31:20]};
            {id_ex.add_en_out, id_ex.sub_en_out, id_ex.xor_en_out,
             id_ex.or_en_out, id_ex.and_en_out} = alu_op;
            id_ex.rs1_take_prev1_out     = p1_rs1;
            id_ex.rs2_take_prev1_out     = p1_rs2;
            issued                       = '{rd: rd, wb_en: 1'b1, is_load: is_lw};
        end
    end

    // Shift the issue history every cycle; reset refills it with bubbles.
    // NOTE: state updates use non-blocking assignments so prev2 takes the old prev1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev1 <= BUBBLE;
            prev2 <= BUBBLE;
        end else begin
            prev2 <= prev1;
            prev1 <= issued;
        end
    end

endmodule

// File: tb/tb_id_stage.sv
// Directed-vector bench for id_stage: decode, regfile bypass, forwarding, stalls, reset.
module tb_id_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr_in;
    logic        instr_valid;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        stall_out;

    int tests_run    = 0;
    int tests_failed = 0;

    id_stage_if bus ();

    id_stage dut (
        .clk         (clk),
        .rst         (rst),
        .instr_in    (instr_in),
        .instr_valid (instr_valid),
        .wb_en       (wb_en),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .stall_out   (stall_out),
        .id_ex       (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    localparam logic [4:0] OP_ADD = 5'b10000;
    localparam logic [4:0] OP_SUB = 5'b01000;
    localparam logic [4:0] OP_XOR = 5'b00100;
    localparam logic [4:0] OP_OR  = 5'b00010;
    localparam logic [4:0] OP_AND = 5'b00001;

    // {stall, rd, wb_en, from_mem, rs2_reg, add, sub, xor, or, and, tp1, tp2}
    function automatic logic [15:0] mk(input logic st, input logic [4:0] rd, input logic wb,
                                       input logic mem, input logic rr, input logic [4:0] op,
                                       input logic t1, input logic t2);
        return {st, rd, wb, mem, rr, op, t1, t2};
    endfunction

    function automatic logic [15:0] obs();
        return {stall_out, bus.rd_addr_out, bus.writeback_en_out, bus.writeback_from_mem_out,
                bus.alu_rs2_reg_out, bus.add_en_out, bus.sub_en_out, bus.xor_en_out,
                bus.or_en_out, bus.and_en_out, bus.rs1_take_prev1_out, bus.rs2_take_prev1_out};
    endfunction

    function automatic logic [31:0] rtype(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] itype(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    logic [15:0] bub;
    logic [15:0] stl;

    // Apply inputs just after a posedge and settle before sampling mid-cycle.
    task automatic drive(input logic [31:0] ins, input logic v, input logic we,
                         input logic [4:0] wa, input logic [31:0] wd);
        instr_in = ins; instr_valid = v; wb_en = we; wb_addr = wa; wb_data = wd;
        #3;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic flush();
        for (int i = 0; i < 2; i++) begin
            drive(32'd0, 1'b0, 1'b0, 5'd0, 32'd0);
            next_cycle();
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        drive(rtype(7'h00, 5'd5, 5'd5, 3'b000, 5'd6), 1'b1, 1'b0, 5'd0, 32'd0);
        tests_run++;
        if (obs() !== bub) begin
            tests_failed++; $display("FAIL reset_flags: got %h expected %h", obs(), bub);
        end
        tests_run++;
        if ({bus.rs1_out, bus.rs2_out, bus.imm_out} !== 96'd0) begin
            tests_failed++;
            $display("FAIL reset_data: got %h %h %h expected 0", bus.rs1_out, bus.rs2_out, bus.imm_out);
        end
        next_cycle();
        rst = 1'b1;
    endtask

    task automatic test_decode();
        logic [31:0] ins [7];
        logic [15:0] ef  [7];
        logic [31:0] ei  [7];
        ins[0] = rtype(7'h20, 5'd0, 5'd0, 3'b000, 5'd10); ef[0] = mk(0, 10, 1, 0, 1, OP_SUB, 0, 0); ei[0] = 32'd0;
        ins[1] = itype(12'hFFB, 5'd0, 3'b000, 5'd11, 7'b0010011); ef[1] = mk(0, 11, 1, 0, 0, OP_ADD, 0, 0); ei[1] = 32'hFFFF_FFFB;
        ins[2] = itype(12'h7FF, 5'd0, 3'b110, 5'd12, 7'b0010011); ef[2] = mk(0, 12, 1, 0, 0, OP_OR, 0, 0);  ei[2] = 32'h0000_07FF;
        ins[3] = itype(12'h800, 5'd0, 3'b111, 5'd13, 7'b0010011); ef[3] = mk(0, 13, 1, 0, 0, OP_AND, 0, 0); ei[3] = 32'hFFFF_F800;
        ins[4] = itype(12'h010, 5'd0, 3'b010, 5'd14, 7'b0000011); ef[4] = mk(0, 14, 1, 1, 0, OP_ADD, 0, 0); ei[4] = 32'h0000_0010;
        ins[5] = rtype(7'h00, 5'd0, 5'd0, 3'b100, 5'd15); ef[5] = mk(0, 15, 1, 0, 1, OP_XOR, 0, 0); ei[5] = 32'd0;
        ins[6] = rtype(7'h01, 5'd0, 5'd0, 3'b000, 5'd16); ef[6] = bub; ei[6] = 32'd0;
        flush();
        for (int i = 0; i < 7; i++) begin
            drive(ins[i], 1'b1, 1'b0, 5'd0, 32'd0);
            tests_run++;
            if (obs() !== ef[i] || bus.imm_out !== ei[i]) begin
                tests_failed++;
                $display("FAIL decode_%0d: got %h imm %h expected %h imm %h", i, obs(), bus.imm_out, ef[i], ei[i]);
            end
            next_cycle();
        end
    endtask

    task automatic test_regfile_bypass();
        flush();
        drive(32'd0, 1'b0, 1'b1, 5'd5, 32'h0000_1234);
        next_cycle();
        drive(rtype(7'h00, 5'd5, 5'd5, 3'b000, 5'd6), 1'b1, 1'b0, 5'd0, 32'd0);
        tests_run++;
        if (obs() !== mk(0, 6, 1, 0, 1, OP_ADD, 0, 0) || bus.rs1_out !== 32'h1234 || bus.rs2_out !== 32'h1234) begin
            tests_failed++;
            $display("FAIL rf_read: got %h %h %h expected 1234 1234", obs(), bus.rs1_out, bus.rs2_out);
        end
        next_cycle();
        drive(rtype(7'h00, 5'd7, 5'd7, 3'b000, 5'd8), 1'b1, 1'b1, 5'd7, 32'hABCD_0000);
        tests_run++;
        if (bus.rs1_out !== 32'hABCD_0000 || bus.rs2_out !== 32'hABCD_0000) begin
            tests_failed++;
            $display("FAIL rf_bypass_new: got %h %h expected abcd0000", bus.rs1_out, bus.rs2_out);
        end
        next_cycle();
        drive(rtype(7'h00, 5'd0, 5'd5, 3'b000, 5'd9), 1'b1, 1'b1, 5'd5, 32'h5555_5555);
        tests_run++;
        if (bus.rs1_out !== 32'h5555_5555 || bus.rs2_out !== 32'd0) begin
            tests_failed++;
            $display("FAIL rf_bypass_over: got %h %h expected 55555555 0", bus.rs1_out, bus.rs2_out);
        end
        next_cycle();
        drive(rtype(7'h00, 5'd7, 5'd5, 3'b000, 5'd16), 1'b1, 1'b0, 5'd0, 32'd0);
        tests_run++;
        if (bus.rs1_out !== 32'h5555_5555 || bus.rs2_out !== 32'hABCD_0000) begin
            tests_failed++;
            $display("FAIL rf_stored: got %h %h expected 55555555 abcd0000", bus.rs1_out, bus.rs2_out);
        end
        next_cycle();
    endtask

    task automatic test_forward();
        flush();
        drive(itype(12'd7, 5'd0, 3'b000, 5'd1, 7'b0010011), 1'b1, 1'b0, 5'd0, 32'd0);
        tests_run++;
        if (obs() !== mk(0, 1, 1, 0, 0, OP_ADD, 0, 0)) begin
            tests_failed++; $display("FAIL fwd_producer: got %h expected %h", obs(), mk(0, 1, 1, 0, 0, OP_ADD, 0, 0));
        end
        next_cycle();
        drive(rtype(7'h00, 5'd1, 5'd1, 3'b000, 5'd2), 1'b1, 1'b0, 5'd0, 32'd0);
        tests_run++;
        if (obs() !== mk(0, 2, 1, 0, 1, OP_ADD, 1, 1)) begin
            tests_failed++; $display("FAIL fwd_both: got %h expected %h", obs(), mk(0, 2, 1, 0, 1, OP_ADD, 1, 1));
        end
        next_cycle();
        drive(rtype(7'h00, 5'd2, 5'd0, 3'b100, 5'd4), 1'b1, 1'b0, 5'd0, 32'd0);
        tests_run++;
        if (obs() !== mk(0, 4, 1, 0, 1, OP_XOR, 0, 1)) begin
            tests_failed++; $display("FAIL fwd_rs2_only: got %h expected %h", obs(), mk(0, 4, 1, 0, 1, OP_XOR, 0, 1));
        end
        next_cycle();
    endtask

    task automatic test_load_use();
        logic [31:0] add_i;
        add_i = rtype(7'h00, 5'd0, 5'd3, 3'b000, 5'd4);
        flush();
        drive(itype(12'd0, 5'd0, 3'b010, 5'd3, 7'b0000011), 1'b1, 1'b0, 5'd0, 32'd0);
        next_cycle();
        for (int i = 0; i < 2; i++) begin
            drive(add_i, 1'b1, 1'b0, 5'd0, 32'd0);
            tests_run++;
            if (obs() !== stl || bus.rs1_out !== 32'd0) begin
                tests_failed++; $display("FAIL load_use_stall_%0d: got %h rs1 %h expected %h", i, obs(), bus.rs1_out, stl);
            end
            next_cycle();
        end
        drive(add_i, 1'b1, 1'b1, 5'd3, 32'hCAFE_0001);
        tests_run++;
        if (obs() !== mk(0, 4, 1, 0, 1, OP_ADD, 0, 0) || bus.rs1_out !== 32'hCAFE_0001 || bus.rs2_out !== 32'd0) begin
            tests_failed++; $display("FAIL load_use_issue: got %h rs1 %h expected cafe0001", obs(), bus.rs1_out);
        end
        next_cycle();
    endtask

    task automatic test_prev2();
        flush();
        drive(itype(12'd3, 5'd0, 3'b000, 5'd1, 7'b0010011), 1'b1, 1'b0, 5'd0, 32'd0);
        next_cycle();
        drive(itype(12'd4, 5'd0, 3'b000, 5'd9, 7'b0010011), 1'b1, 1'b0, 5'd0, 32'd0);
        next_cycle();
        drive(rtype(7'h00, 5'd0, 5'd1, 3'b100, 5'd2), 1'b1, 1'b0, 5'd0, 32'd0);
        tests_run++;
        if (obs() !== stl) begin
            tests_failed++; $display("FAIL prev2_stall: got %h expected %h", obs(), stl);
        end
        next_cycle();
        drive(rtype(7'h00, 5'd0, 5'd1, 3'b100, 5'd2), 1'b1, 1'b1, 5'd1, 32'd3);
        tests_run++;
        if (obs() !== mk(0, 2, 1, 0, 1, OP_XOR, 0, 0) || bus.rs1_out !== 32'd3) begin
            tests_failed++; $display("FAIL prev2_issue: got %h rs1 %h expected 3", obs(), bus.rs1_out);
        end
        next_cycle();
    endtask

    task automatic test_x0();
        flush();
        drive(32'd0, 1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF);
        next_cycle();
        drive(rtype(7'h00, 5'd0, 5'd0, 3'b000, 5'd10), 1'b1, 1'b1, 5'd0, 32'hFFFF_FFFF);
        tests_run++;
        if (bus.rs1_out !== 32'd0 || bus.rs2_out !== 32'd0) begin
            tests_failed++; $display("FAIL x0_read: got %h %h expected 0 0", bus.rs1_out, bus.rs2_out);
        end
        next_cycle();
        drive(itype(12'd0, 5'd0, 3'b010, 5'd0, 7'b0000011), 1'b1, 1'b0, 5'd0, 32'd0);
        next_cycle();
        drive(rtype(7'h00, 5'd0, 5'd0, 3'b000, 5'd17), 1'b1, 1'b0, 5'd0, 32'd0);
        tests_run++;
        if (obs() !== mk(0, 17, 1, 0, 1, OP_ADD, 0, 0)) begin
            tests_failed++; $display("FAIL x0_producer: got %h expected %h", obs(), mk(0, 17, 1, 0, 1, OP_ADD, 0, 0));
        end
        next_cycle();
        drive(itype(12'd0, 5'd0, 3'b010, 5'd18, 7'b0000011), 1'b1, 1'b0, 5'd0, 32'd0);
        next_cycle();
        drive({7'd0, 5'd18, 5'd18, 3'b000, 5'd0, 7'b1100011}, 1'b1, 1'b0, 5'd0, 32'd0);
        tests_run++;
        if (obs() !== bub) begin
            tests_failed++; $display("FAIL unsupported_op: got %h expected %h", obs(), bub);
        end
        drive(rtype(7'h00, 5'd0, 5'd18, 3'b000, 5'd4), 1'b0, 1'b0, 5'd0, 32'd0);
        tests_run++;
        if (obs() !== bub) begin
            tests_failed++; $display("FAIL invalid_no_stall: got %h expected %h", obs(), bub);
        end
        next_cycle();
    endtask

    task automatic test_reset_mid_stall();
        logic [31:0] add_i;
        add_i = rtype(7'h00, 5'd0, 5'd3, 3'b000, 5'd4);
        flush();
        drive(itype(12'd0, 5'd0, 3'b010, 5'd3, 7'b0000011), 1'b1, 1'b0, 5'd0, 32'd0);
        next_cycle();
        drive(add_i, 1'b1, 1'b0, 5'd0, 32'd0);
        tests_run++;
        if (obs() !== stl) begin
            tests_failed++; $display("FAIL mid_stall_pre: got %h expected %h", obs(), stl);
        end
        rst = 1'b0;
        #1;
        tests_run++;
        if (obs() !== bub) begin
            tests_failed++; $display("FAIL mid_stall_reset: got %h expected %h", obs(), bub);
        end
        next_cycle();
        rst = 1'b1;
        drive(add_i, 1'b1, 1'b0, 5'd0, 32'd0);
        tests_run++;
        if (obs() !== mk(0, 4, 1, 0, 1, OP_ADD, 0, 0) || bus.rs1_out !== 32'hCAFE_0001) begin
            tests_failed++; $display("FAIL post_reset_issue: got %h rs1 %h expected cafe0001", obs(), bus.rs1_out);
        end
        next_cycle();
    endtask

    initial begin
        bub = mk(0, 0, 1, 0, 0, OP_ADD, 0, 0);
        stl = mk(1, 0, 1, 0, 0, OP_ADD, 0, 0);
        test_reset();
        test_decode();
        test_regfile_bypass();
        test_forward();
        test_load_use();
        test_prev2();
        test_x0();
        test_reset_mid_stall();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
